// File: rtl/chess_clock_ctrl.sv
// rtl/chess_clock_ctrl.sv - two-player chess clock FSM with per-player mm:ss countdown
// Optional per-move increment enabled by defining CHESS_CLOCK_INCREMENT_EN.
module chess_clock_ctrl #(
    parameter int INIT_MIN = 5,
    parameter int INIT_SEG = 0,
    parameter int INC_SEG  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       btn1,
    input  logic       btn2,
    output logic [5:0] min1,
    output logic [5:0] seg1,
    output logic [5:0] min2,
    output logic [5:0] seg2,
    output logic       turn,
    output logic       running,
    output logic       flag1,
    output logic       flag2
);

    typedef enum logic [2:0] {IDLE, RUN1, RUN2, PAUSE, FLAG} state_t;

    localparam logic [5:0] INIT_M = 6'(INIT_MIN);
    localparam logic [5:0] INIT_S = 6'(INIT_SEG);
    localparam logic [6:0] INC_S  = 7'(INC_SEG);

    state_t     state_q, state_d;
    logic [5:0] min1_q, min1_d, seg1_q, seg1_d;
    logic [5:0] min2_q, min2_d, seg2_q, seg2_d;
    logic       turn_q, turn_d, running_q, running_d;
    logic       flag1_q, flag1_d, flag2_q, flag2_d;

    // One-second countdown that sticks at 0:00 rather than wrapping.
    function automatic logic [11:0] dec_time(input logic [5:0] m, input logic [5:0] s);
        if (s != 6'd0)
            return {m, s - 6'd1};
        else if (m != 6'd0)
            return {m - 6'd1, 6'd59};
        else
            return {m, s};
    endfunction

    // Adds the move bonus with seconds carry; saturates at 59:59.
    function automatic logic [11:0] inc_time(input logic [5:0] m, input logic [5:0] s);
        logic [6:0] ss;
        logic [6:0] mm;
        ss = {1'b0, s} + INC_S;
        mm = {1'b0, m};
        if (ss >= 7'd60) begin
            ss = ss - 7'd60;
            mm = mm + 7'd1;
        end
        if (mm > 7'd59)
            return {6'd59, 6'd59};
        return {mm[5:0], ss[5:0]};
    endfunction

    always_comb begin
        state_d = state_q;
        min1_d  = min1_q;
        seg1_d  = seg1_q;
        min2_d  = min2_q;
        seg2_d  = seg2_q;
        turn_d  = turn_q;
        flag1_d = flag1_q;
        flag2_d = flag2_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = RUN1;
            end
            RUN1: begin
                if (tick)
                    {min1_d, seg1_d} = dec_time(min1_q, seg1_q);
                // Flag beats both pause and a same-cycle move.
                if ({min1_d, seg1_d} == 12'd0) begin
                    state_d = FLAG;
                    flag1_d = 1'b1;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (btn1) begin
                    state_d = RUN2;
                    turn_d  = 1'b1;
`ifdef CHESS_CLOCK_INCREMENT_EN
                    {min1_d, seg1_d} = inc_time(min1_d, seg1_d);
`endif
                end
            end
            RUN2: begin
                if (tick)
                    {min2_d, seg2_d} = dec_time(min2_q, seg2_q);
                if ({min2_d, seg2_d} == 12'd0) begin
                    state_d = FLAG;
                    flag2_d = 1'b1;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (btn2) begin
                    state_d = RUN1;
                    turn_d  = 1'b0;
`ifdef CHESS_CLOCK_INCREMENT_EN
                    {min2_d, seg2_d} = inc_time(min2_d, seg2_d);
`endif
                end
            end
            PAUSE: begin
                if (pause)
                    state_d = turn_q ? RUN2 : RUN1;
            end
            FLAG: begin
                if (start) begin
                    state_d = IDLE;
                    min1_d  = INIT_M;
                    seg1_d  = INIT_S;
                    min2_d  = INIT_M;
                    seg2_d  = INIT_S;
                    turn_d  = 1'b0;
                    flag1_d = 1'b0;
                    flag2_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN1) || (state_d == RUN2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            min1_q    <= INIT_M;
            seg1_q    <= INIT_S;
            min2_q    <= INIT_M;
            seg2_q    <= INIT_S;
            turn_q    <= 1'b0;
            running_q <= 1'b0;
            flag1_q   <= 1'b0;
            flag2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min1_q    <= min1_d;
            seg1_q    <= seg1_d;
            min2_q    <= min2_d;
            seg2_q    <= seg2_d;
            turn_q    <= turn_d;
            running_q <= running_d;
            flag1_q   <= flag1_d;
            flag2_q   <= flag2_d;
        end
    end

    assign min1    = min1_q;
    assign seg1    = seg1_q;
    assign min2    = min2_q;
    assign seg2    = seg2_q;
    assign turn    = turn_q;
    assign running = running_q;
    assign flag1   = flag1_q;
    assign flag2   = flag2_q;

endmodule
